bus_ram_mirrored: RTL



---
 rtl/bus_ram_mirrored.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/bus_ram_mirrored.sv
// -----------------------------------------------------------------------------
// bus_ram_mirrored
//
// Single-port RAM on the CPU address/data bus. A 2^WINDOW_LOG2 window at BASE is
// decoded, and a smaller 2^DEPTH_LOG2 physical array is mirrored across it (e.g.
// NES 2KB WRAM repeated four times in $0000-$1FFF). After reset an optional clear
// sequencer fills the array with CLEAR_VAL before any bus access is accepted.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   addr      in   bus address [ADDR_W]
//   din       in   write data [DATA_W]
//   rw_n      in   1 = read, 0 = write
//   cs_n      in   chip select, active-low
//   wp        in   runtime write protect
//   dout      out  read data, held between reads [DATA_W]
//   rd_valid  out  one-cycle strobe per accepted read, RD_LAT cycles after it
//   hit       out  combinational decode: selected and inside the window
//   ready     out  clear finished, accesses accepted
//   wr_err    out  one-cycle strobe after a rejected write hit
//
// Bus handshake: there is no back-pressure. An access is accepted on any rising
// edge where ready-state is RUN and hit=1. A read is answered by rd_valid=1 exactly
// RD_LAT cycles later, one answer per accepted read, in order. A write is either
// committed at that edge or answered by wr_err=1 in the following cycle.
// -----------------------------------------------------------------------------
module bus_ram_mirrored #(
  parameter int                 DATA_W       = 8,
  parameter int                 ADDR_W       = 16,
  parameter int                 DEPTH_LOG2   = 11,
  parameter int                 WINDOW_LOG2  = 13,
  parameter logic [ADDR_W-1:0]  BASE         = '0,
  parameter int                 RD_LAT       = 1,
  parameter int                 CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL    = '0,
  parameter int                 READ_ONLY    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rw_n,
  input  logic              cs_n,
  input  logic              wp,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              hit,
  output logic              ready,
  output logic              wr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    wr_err_q, wr_err_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]       s1_data_q, s1_data_d;

  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    win_match;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    rd_fire;
  logic                    wr_rej;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    addr_unused;

  // ---------------------------------------------------------------------------
  // Decode. Address bits between DEPTH_LOG2 and WINDOW_LOG2 are deliberately
  // ignored so the physical array repeats across the window.
  // ---------------------------------------------------------------------------
  generate
    if (WINDOW_LOG2 >= ADDR_W) begin : g_win_all
      assign win_match = 1'b1;
    end else begin : g_win_cmp
      assign win_match = (addr[ADDR_W-1:WINDOW_LOG2] == BASE[ADDR_W-1:WINDOW_LOG2]);
    end
  endgenerate

  assign hit         = ~cs_n & win_match;
  assign idx         = addr[DEPTH_LOG2-1:0];
  assign addr_unused = ^addr;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. CLEAR walks every index once, then hands over to RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {DEPTH_LOG2{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The single write port is owned by the clear sequencer in
  // CLEAR and by the bus in RUN; bus accesses during CLEAR are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_fire   = 1'b0;
    wr_rej    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = din;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_VAL;
      end
      ST_RUN: begin
        rd_fire = hit & rw_n;
        if (hit && !rw_n) begin
          if (wp || (READ_ONLY != 0)) begin
            wr_rej = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      default: begin
        rd_fire = 1'b0;
      end
    endcase
  end

  // ready follows the state one cycle late so it is low throughout reset and
  // rises the cycle after the final clear write.
  always_comb begin
    ready_d  = (state_d == ST_RUN);
    wr_err_d = wr_rej;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign ready  = ready_q;
  assign wr_err = wr_err_q;

  // ---------------------------------------------------------------------------
  // Storage: contents are not reset; only the clear sequencer initialises them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Stage 1 captures the array at the accepting edge; the data
  // registers only load on a valid read so dout holds the last value read.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? mem_q[idx] : s1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign dout     = s1_data_q;
      assign rd_valid = s1_valid_q;
    end else if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid_q, s2_valid_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign dout     = s2_data_q;
      assign rd_valid = s2_valid_q;
    end else begin : g_lat_bad
      $error("bus_ram_mirrored: RD_LAT must be 1 or 2");
    end
  endgenerate

endmodule
